// File: rtl/risc_pkg.sv
// risc_pkg: opcodes, ALU and next-PC encodings, and sequencer states shared by the control path
package risc_pkg;
   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_ADDI = 6'h01;
   localparam logic [5:0] OP_LD   = 6'h02;
   localparam logic [5:0] OP_ST   = 6'h03;
   localparam logic [5:0] OP_BEQZ = 6'h04;
   localparam logic [5:0] OP_BNEZ = 6'h05;
   localparam logic [5:0] OP_JMP  = 6'h06;
   localparam logic [5:0] OP_HALT = 6'h3f;
   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [1:0] PC_INC  = 2'd0;
   localparam logic [1:0] PC_BR   = 2'd1;
   localparam logic [1:0] PC_JMP  = 2'd2;
   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// mc_ctrl_fsm_if: shared memory request/ready handshake between sequencer and memory
interface mc_ctrl_fsm_if;
   logic        mem_req;
   logic        mem_we;
   logic        addr_sel;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   modport master (output mem_req, mem_we, addr_sel, input mem_ready, mem_rdata);
   modport slave (input mem_req, mem_we, addr_sel, output mem_ready, mem_rdata);
endinterface

// File: rtl/imm_ext.sv
// imm_ext: sign-extends the 16-bit or 26-bit instruction immediate field to 32 bits
module imm_ext (
   input  logic [25:0] field,
   input  logic        ext_sel,
   output logic [31:0] imm
);
   assign imm = ext_sel ? {{6{field[25]}}, field} : {{16{field[15]}}, field[15:0]};
endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle sequencer driving fetch, decode, ALU, memory and write-back
module mc_ctrl_fsm
   import risc_pkg::*;
#(
   parameter int W_OP    = 6,
   parameter int W_ALUOP = 4
) (
   input  logic               clk,
   input  logic               rst,
   mc_ctrl_fsm_if.master      bus,
   output logic [31:0]        ir,
   output logic [31:0]        imm,
   output logic               ext_sel,
   output logic               alu_src_imm,
   output logic [W_ALUOP-1:0] alu_op,
   input  logic               alu_zero,
   output logic               reg_we,
   output logic               wb_sel,
   output logic               pc_we,
   output logic [1:0]         pc_sel,
   output logic               halted,
   output logic               illegal
);
   state_t          st;
   logic [W_OP-1:0] op;
   logic [31:0]     imm_x;
   logic is_r, is_addi, is_ld, is_st, is_beqz, is_bnez, is_jmp, is_halt, legal, taken;
   assign op      = ir[31 -: W_OP];
   assign is_r    = op == OP_R;
   assign is_addi = op == OP_ADDI;
   assign is_ld   = op == OP_LD;
   assign is_st   = op == OP_ST;
   assign is_beqz = op == OP_BEQZ;
   assign is_bnez = op == OP_BNEZ;
   assign is_jmp  = op == OP_JMP;
   assign is_halt = op == OP_HALT;
   assign legal   = is_r || is_addi || is_ld || is_st || is_beqz || is_bnez || is_jmp || is_halt;
   assign taken   = is_jmp || (is_beqz && alu_zero) || (is_bnez && !alu_zero);
   assign ext_sel = st == S_DECODE && is_jmp;
   imm_ext u_ext (.field(ir[25:0]), .ext_sel, .imm(imm_x));
   // Reset holds st at FETCH, so the FETCH-driven strobes are gated to drop with rst at once
   assign bus.mem_req  = !rst && (st == S_FETCH || st == S_MEM);
   assign bus.mem_we   = st == S_MEM && is_st;
   assign bus.addr_sel = st == S_MEM;
   assign pc_we        = !rst && (st == S_FETCH ? bus.mem_ready : st == S_EXEC && taken);
   assign pc_sel       = st != S_EXEC ? PC_INC : is_jmp ? PC_JMP : PC_BR;
   assign alu_src_imm  = st == S_EXEC && (is_addi || is_ld || is_st);
   assign alu_op       = is_r ? ir[W_ALUOP-1:0] : W_ALUOP'(ALU_ADD);
   assign reg_we       = st == S_WB;
   assign wb_sel       = st == S_WB && is_ld;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         st      <= S_FETCH;
         ir      <= '0;
         imm     <= '0;
         illegal <= 1'b0;
         halted  <= 1'b0;
      end else
         case (st)
            S_FETCH: if (bus.mem_ready) begin
               ir <= bus.mem_rdata;
               st <= S_DECODE;
            end
            S_DECODE: begin
               imm     <= imm_x;
               st      <= legal && !is_halt ? S_EXEC : S_HALT;
               illegal <= illegal || !legal;
               halted  <= !legal || is_halt;
            end
            S_EXEC: st <= is_r || is_addi ? S_WB : is_ld || is_st ? S_MEM : S_FETCH;
            S_MEM: if (bus.mem_ready) st <= is_st ? S_FETCH : S_WB;
            S_WB: st <= S_FETCH;
            default: ;
         endcase
endmodule
